// File: rtl/fifo_flags_pkg.sv
// Shared defaults and operation encoding for the fifo_flags queue.
package fifo_flags_pkg;

  localparam int unsigned DEF_WORD_BITS    = 8;
  localparam int unsigned DEF_ADDR_BITS    = 4;
  localparam int          DEF_AFULL_MARGIN = 4;
  localparam int          DEF_AEMPTY_LEVEL = 2;

  // Accepted-operation classes, built as {push, pop}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WORD_BITS storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [WORD_BITS-1:0] i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [WORD_BITS-1:0] o_rdata
);

  logic [WORD_BITS-1:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_flags.sv
// Show-ahead synchronous FIFO with registered occupancy flags and sticky error flags.
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int unsigned WORD_BITS    = DEF_WORD_BITS,
  parameter int unsigned ADDR_BITS    = DEF_ADDR_BITS,
  parameter int          AFULL_LEVEL  = int'(2**ADDR_BITS) - DEF_AFULL_MARGIN,
  parameter int          AEMPTY_LEVEL = DEF_AEMPTY_LEVEL
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [WORD_BITS-1:0] i_wdata,
  input  logic                 i_rd,
  input  logic                 i_clr_err,
  output logic [WORD_BITS-1:0] o_rdata,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_afull,
  output logic                 o_aempty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic empty_q, empty_d, full_q, full_d;
  logic afull_q, afull_d, aempty_q, aempty_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic push, pop;
  fifo_op_e op;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign push = i_wr && (!full_q || i_rd);
  assign pop  = i_rd && !empty_q;
  assign op   = fifo_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      OP_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      OP_POP: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      OP_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase

    // Flags track the next occupancy so they are registered yet current
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    afull_d  = (int'(count_d) >= AFULL_LEVEL);
    aempty_d = (int'(count_d) <= AEMPTY_LEVEL);

    // A new error in the clearing cycle wins over i_clr_err
    overflow_d  = (i_wr && full_q && !i_rd) || (overflow_q && !i_clr_err);
    underflow_d = (i_rd && empty_q) || (underflow_q && !i_clr_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WORD_BITS (WORD_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (push && !i_reset),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_wdata),
    .i_raddr (rd_ptr_q),
    .o_rdata (o_rdata)
  );

  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_afull     = afull_q;
  assign o_aempty    = aempty_q;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule
